// File: rtl/mp_add_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer:
// limb width and the sequencer state encoding.
package mp_add_pkg;

  localparam int LIMB_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mp_add_sequencer_adder16b.sv
// Adder16b: the shared 16-bit adder datapath with carry-in and carry-out.
module adder16b (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        ci,
  output logic [15:0] s,
  output logic        co
);

  // Single 17-bit addition; the top bit is the carry-out.
  always_comb begin
    {co, s} = {1'b0, a} + {1'b0, b} + {16'h0000, ci};
  end

endmodule

// File: rtl/mp_add_sequencer.sv
// Multi-precision add/subtract sequencer: one limb per cycle through a single
// shared 16-bit adder, least-significant limb first, carry chained in a register.
module mp_add_sequencer
  import mp_add_pkg::*;
#(
  parameter int WORDS = 4,
  parameter int CNT_W = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    sub,
  input  logic                    ci,
  input  logic [16*WORDS-1:0]     a,
  input  logic [16*WORDS-1:0]     b,
  output logic                    busy,
  output logic                    done,
  output logic [16*WORDS-1:0]     r,
  output logic                    co,
  output logic                    ovf
);

  localparam int OP_W = LIMB_W * WORDS;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);

  state_t              state_r;
  state_t              state_nx_s;
  logic [OP_W-1:0]     op_a_r;
  logic [OP_W-1:0]     op_b_r;
  logic [OP_W-1:0]     r_r;
  logic                carry_r;
  logic                sub_r;
  logic                co_r;
  logic                ovf_r;
  logic                busy_r;
  logic                done_r;
  logic [CNT_W-1:0]    idx_r;
  logic [CNT_W+3:0]    base_s;
  logic [LIMB_W-1:0]   limb_a_s;
  logic [LIMB_W-1:0]   limb_b_s;
  logic [LIMB_W-1:0]   sum_s;
  logic                add_co_s;
  logic                last_s;

  // Bit offset of the current limb (idx * 16).
  assign base_s   = {idx_r, 4'h0};
  assign limb_a_s = op_a_r[base_s +: LIMB_W];
  assign limb_b_s = op_b_r[base_s +: LIMB_W];
  assign last_s   = (idx_r == LAST_IDX);

  adder16b u_adder (
    .a  (limb_a_s),
    .b  (limb_b_s),
    .ci (carry_r),
    .s  (sum_s),
    .co (add_co_s)
  );

  // Next-state decode.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nx_s = ST_RUN;
        else       state_nx_s = ST_IDLE;
      end
      ST_RUN: begin
        if (last_s) state_nx_s = ST_DONE;
        else        state_nx_s = ST_RUN;
      end
      ST_DONE: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State register plus busy/done flags registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s != ST_IDLE);
      done_r  <= (state_nx_s == ST_DONE);
    end
  end

  // Operand capture and limb-serial datapath; subtraction is a + ~b + ~ci.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a_r  <= '0;
      op_b_r  <= '0;
      r_r     <= '0;
      carry_r <= 1'b0;
      sub_r   <= 1'b0;
      idx_r   <= '0;
      co_r    <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            op_a_r  <= a;
            op_b_r  <= sub ? ~b : b;
            carry_r <= sub ? ~ci : ci;
            sub_r   <= sub;
            idx_r   <= '0;
            r_r     <= '0;
            co_r    <= 1'b0;
            ovf_r   <= 1'b0;
          end
        end
        ST_RUN: begin
          r_r[base_s +: LIMB_W] <= sum_s;
          carry_r               <= add_co_s;
          idx_r                 <= idx_r + CNT_W'(1);
          if (last_s) begin
            co_r  <= sub_r ^ add_co_s;
            ovf_r <= (op_a_r[OP_W-1] == op_b_r[OP_W-1]) &&
                     (sum_s[LIMB_W-1] != op_a_r[OP_W-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign r    = r_r;
  assign co   = co_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Self-checking bench for mp_add_sequencer (WORDS=4): an arithmetic reference
// model compared every cycle, plus directed vectors with literal expectations.
module tb_mp_add_sequencer;

  localparam int W = 4;
  localparam int N = 16 * W;

  logic         clk = 1'b0;
  logic         rst_n, start, sub, ci;
  logic [N-1:0] a, b, r;
  logic         busy, done, co, ovf;

  int n_cmp  = 0;
  int n_fail = 0;
  int done_cnt = 0;
  bit cmp_en = 1'b0;

  // Reference model state: phase 0 idle, 1..W running, W+1 done.
  int           m_phase = 0;
  logic [N-1:0] m_r = '0;
  logic         m_co = 1'b0, m_ovf = 1'b0;
  bit           m_rvalid = 1'b1;
  logic [N-1:0] p_r;
  logic         p_co, p_ovf;

  mp_add_sequencer #(.WORDS(W), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .ci(ci),
    .a(a), .b(b), .busy(busy), .done(done), .r(r), .co(co), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: full-width arithmetic result computed at accept, revealed on done.
  always @(posedge clk) begin
    logic [N:0] full;
    if (!rst_n) begin
      m_phase = 0; m_r = '0; m_co = 1'b0; m_ovf = 1'b0; m_rvalid = 1'b1;
    end else if (m_phase == 0) begin
      if (start) begin
        if (!sub) begin
          full  = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};
          p_ovf = (a[N-1] == b[N-1]) && (full[N-1] != a[N-1]);
        end else begin
          full  = {1'b0, a} - {1'b0, b} - {{N{1'b0}}, ci};
          p_ovf = (a[N-1] != b[N-1]) && (full[N-1] != a[N-1]);
        end
        p_r = full[N-1:0]; p_co = full[N];
        m_phase = 1; m_rvalid = 1'b0;
      end
    end else if (m_phase <= W) begin
      m_phase++;
      if (m_phase == W + 1) begin
        m_r = p_r; m_co = p_co; m_ovf = p_ovf; m_rvalid = 1'b1;
      end
    end else begin
      m_phase = 0;
    end
  end

  // Compare process, sampled on the falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", N'(busy), N'(m_phase != 0));
      check("done", N'(done), N'(m_phase == W + 1));
      if (m_rvalid) begin
        check("r", r, m_r);
        check("co", N'(co), N'(m_co));
        check("ovf", N'(ovf), N'(m_ovf));
      end
      if (done) done_cnt++;
    end
  end

  task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb_, input logic tci,
                        input logic tsub, input logic [N-1:0] er, input logic eco,
                        input logic eovf, input string name);
    int cyc;
    @(negedge clk);
    a = ta; b = tb_; ci = tci; sub = tsub; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~ta; b = ta ^ tb_; ci = ~tci; sub = ~tsub;
    cyc = 1;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_latency"}, N'(cyc), N'(5));
    check({name, "_r"}, r, er);
    check({name, "_co"}, N'(co), N'(eco));
    check({name, "_ovf"}, N'(ovf), N'(eovf));
  endtask

  initial begin
    int dc0;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; ci = 1'b0; a = '0; b = '0;
    @(posedge clk);
    #1 cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", N'(busy), N'(0));
    check("rst_done", N'(done), N'(0));
    check("rst_r", r, N'(0));
    check("rst_co_ovf", N'({co, ovf}), N'(0));
    rst_n = 1'b1;

    run_op(64'd50, 64'd100, 1'b0, 1'b0, 64'd150, 1'b0, 1'b0, "add_small");
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, "ripple");
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, "ovf_pos");
    run_op(64'd40000, 64'd40000, 1'b1, 1'b0, 64'h0000_0000_0001_3881, 1'b0, 1'b0, "add_ci");
    run_op(64'd500, 64'd100, 1'b0, 1'b1, 64'd400, 1'b0, 1'b0, "sub_pos");
    run_op(64'd100, 64'd500, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FE70, 1'b1, 1'b0, "sub_neg");
    run_op(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, "sub_ovf");
    repeat (3) @(negedge clk);
    check("r_held", r, 64'h7FFF_FFFF_FFFF_FFFF);

    // Second start during RUN must be ignored.
    dc0 = done_cnt;
    @(negedge clk);
    a = 64'd7; b = 64'd8; ci = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 64'd1000; b = 64'd1000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("single_done", N'(done_cnt - dc0), N'(1));
    check("ignored_r", r, 64'd15);

    // Reset sampled at the third RUN edge aborts the operation.
    dc0 = done_cnt;
    a = 64'h1234; b = 64'h1111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", N'(busy), N'(0));
    check("abort_done", N'(done), N'(0));
    check("abort_r", r, N'(0));
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_no_done", N'(done_cnt - dc0), N'(0));
    run_op(64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 1'b0, 1'b0,
           64'h0011_0022_0033_0044, 1'b0, 1'b0, "after_rst");

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
